// File: rtl/rotl_pipe_if.sv
// Valid/ready stream bundle for the pipelined left-rotate unit.
// The master side produces words and consumes results; the slave side is the rotator.
interface rotl_pipe_if #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [SHW-1:0]   in_amt;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   modport master (
      output in_valid, in_data, in_amt, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, in_amt, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/rotl_pipe.sv
// Pipelined circular left rotate: stage k conditionally rotates by 2^k, so SHW
// register stages cover any amount 0..WIDTH-1 at one word per cycle.
module rotl_pipe #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic        clk,
   input  logic        rst,
   rotl_pipe_if.slave  bus
);

   logic [SHW-1:0]   valid_q;
   logic [WIDTH-1:0] data_q [SHW];
   logic [SHW-1:0]   amt_q  [SHW];

   logic [SHW:0]     ready;
   logic             in_ready_int;
   logic [SHW-1:0]   src_valid;
   logic [WIDTH-1:0] src_data [SHW];
   logic [SHW-1:0]   src_amt  [SHW];
   logic [WIDTH-1:0] nxt_data [SHW];
   logic             unused_amt;

   function automatic logic [WIDTH-1:0] rotl_pow2(input logic [WIDTH-1:0] x, input int k);
      int s;
      s = 1 << k;
      return (x << s) | (x >> (WIDTH - s));
   endfunction

   // A stage may load whenever it is empty or its downstream neighbour is moving,
   // which lets bubbles collapse while the output is stalled.
   always_comb begin
      ready[SHW] = bus.out_ready;
      for (int k = SHW - 1; k >= 0; k--) begin
         ready[k] = !valid_q[k] || ready[k+1];
      end
      in_ready_int = ready[0] && !rst;
   end

   always_comb begin
      src_valid[0] = bus.in_valid && in_ready_int;
      src_data[0]  = bus.in_data;
      src_amt[0]   = bus.in_amt;
      for (int k = 1; k < SHW; k++) begin
         src_valid[k] = valid_q[k-1];
         src_data[k]  = data_q[k-1];
         src_amt[k]   = amt_q[k-1];
      end
      for (int k = 0; k < SHW; k++) begin
         nxt_data[k] = src_amt[k][k] ? rotl_pow2(src_data[k], k) : src_data[k];
      end
   end

   // Each stage either advances from upstream or holds everything it has.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         for (int k = 0; k < SHW; k++) begin
            data_q[k] <= '0;
            amt_q[k]  <= '0;
         end
      end else begin
         for (int k = 0; k < SHW; k++) begin
            if (ready[k]) begin
               valid_q[k] <= src_valid[k];
               data_q[k]  <= nxt_data[k];
               amt_q[k]   <= src_amt[k];
            end
         end
      end
   end

   // Only one amount bit is consumed per stage; the rest ride along unused.
   always_comb begin
      unused_amt = 1'b0;
      for (int k = 0; k < SHW; k++) begin
         unused_amt = unused_amt ^ (^amt_q[k]);
      end
   end

   assign bus.in_ready  = in_ready_int;
   assign bus.out_valid = valid_q[SHW-1];
   assign bus.out_data  = data_q[SHW-1];

endmodule
